// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA raster timing path.
// Defaults describe 640x480@60 with a 25 MHz pixel rate from a 100 MHz system clock.
package vga_pkg;

    localparam int unsigned VGA_CLK_DIV  = 4;
    localparam int unsigned VGA_CW       = 10;

    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;

    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;

    function automatic int unsigned seg_total(input int unsigned sync, input int unsigned bp,
                                              input int unsigned active, input int unsigned fp);
        return sync + bp + active + fp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync/active/offset decoded from its next-state value,
// so the registered outputs in the parent line up with the count shown in the same cycle.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned SYNC   = VGA_H_SYNC,
    parameter int unsigned BP     = VGA_H_BP,
    parameter int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned FP     = VGA_H_FP,
    parameter logic        POL    = 1'b0,
    parameter int unsigned CW     = VGA_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step_i,
    input  logic          carry_i,
    output logic [CW-1:0] count_o,
    output logic          wrap_o,
    output logic          sync_d_o,
    output logic          active_d_o,
    output logic [CW-1:0] offset_d_o
);

    localparam int unsigned   TOTAL    = seg_total(SYNC, BP, ACTIVE, FP);
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
    localparam logic [CW-1:0] ACT_LO   = CW'(SYNC + BP);
    localparam logic [CW-1:0] ACT_HI   = CW'(SYNC + BP + ACTIVE);

    logic [CW-1:0] count_q, count_d;

    assign wrap_o  = (count_q == LAST);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (step_i && carry_i) begin
            count_d = wrap_o ? '0 : count_q + CW'(1);
        end
    end

    always_comb begin
        sync_d_o   = (count_d < SYNC_END) ? POL : ~POL;
        active_d_o = (count_d >= ACT_LO) && (count_d < ACT_HI);
        offset_d_o = active_d_o ? (count_d - ACT_LO) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate clock enable, horizontal/vertical axis counters,
// and registered sync, blanking, coordinate and line/frame strobe outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned CW       = VGA_CW,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pix_en,
    output logic          hSync,
    output logic          vSync,
    output logic          bright,
    output logic [CW-1:0] hCount,
    output logic [CW-1:0] vCount,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned    H_TOTAL  = seg_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int unsigned    V_TOTAL  = seg_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int unsigned    DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_chk_div
        $fatal(1, "vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_TOTAL >= (1 << CW)) begin : g_chk_h
        $fatal(1, "vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL >= (1 << CW)) begin : g_chk_v
        $fatal(1, "vga_timing_gen: V_TOTAL does not fit in CW bits");
    end

    logic [DW-1:0] div_q, div_d;
    logic          tick;

    // tick is the cycle whose closing edge advances the counters and raises pix_en
    assign tick = en && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = tick ? '0 : div_q + DW'(1);
        end
    end

    logic          h_wrap, v_wrap;
    logic          h_sync_d, v_sync_d;
    logic          h_active_d, v_active_d;
    logic [CW-1:0] h_off_d, v_off_d;

    vga_axis_counter #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .POL    (HS_POL),
        .CW     (CW)
    ) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .step_i     (tick),
        .carry_i    (1'b1),
        .count_o    (hCount),
        .wrap_o     (h_wrap),
        .sync_d_o   (h_sync_d),
        .active_d_o (h_active_d),
        .offset_d_o (h_off_d)
    );

    vga_axis_counter #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .POL    (VS_POL),
        .CW     (CW)
    ) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .step_i     (tick),
        .carry_i    (h_wrap),
        .count_o    (vCount),
        .wrap_o     (v_wrap),
        .sync_d_o   (v_sync_d),
        .active_d_o (v_active_d),
        .offset_d_o (v_off_d)
    );

    logic          bright_d;
    logic          pix_en_q, hsync_q, vsync_q, bright_q, line_start_q, frame_start_q;
    logic [CW-1:0] pixel_x_q, pixel_y_q;

    assign bright_d = h_active_d && v_active_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            hsync_q       <= HS_POL;
            vsync_q       <= VS_POL;
            bright_q      <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= tick;
            hsync_q       <= h_sync_d;
            vsync_q       <= v_sync_d;
            bright_q      <= bright_d;
            pixel_x_q     <= bright_d ? h_off_d : '0;
            pixel_y_q     <= bright_d ? v_off_d : '0;
            line_start_q  <= tick && h_wrap;
            frame_start_q <= tick && h_wrap && v_wrap;
        end
    end

    assign pix_en      = pix_en_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign bright      = bright_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter instance and a tiny CLK_DIV=1 raster, both
// checked every cycle against a behavioural raster model through per-instance scoreboards.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix;
        logic       hs;
        logic       vs;
        logic       br;
        logic       ls;
        logic       fs;
        logic [9:0] hc;
        logic [9:0] vc;
        logic [9:0] px;
        logic [9:0] py;
    } obs_t;

    typedef struct packed {
        int   div;
        int   h;
        int   v;
        logic pix;
        logic ls;
        logic fs;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, en_d, rst_s, en_s;
    logic       pix_d, hs_d, vs_d, br_d, ls_d, fs_d;
    logic [9:0] hc_d, vc_d, px_d, py_d;
    logic       pix_s, hs_s, vs_s, br_s, ls_s, fs_s;
    logic [3:0] hc_s, vc_s, px_s, py_s;

    vga_timing_gen u_dut_def (
        .clk         (clk),
        .reset       (rst_d),
        .en          (en_d),
        .pix_en      (pix_d),
        .hSync       (hs_d),
        .vSync       (vs_d),
        .bright      (br_d),
        .hCount      (hc_d),
        .vCount      (vc_d),
        .pixel_x     (px_d),
        .pixel_y     (py_d),
        .line_start  (ls_d),
        .frame_start (fs_d)
    );

    vga_timing_gen #(
        .CLK_DIV  (1),
        .CW       (4),
        .H_SYNC   (2),
        .H_BP     (1),
        .H_ACTIVE (4),
        .H_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .V_ACTIVE (3),
        .V_FP     (1),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1)
    ) u_dut_sml (
        .clk         (clk),
        .reset       (rst_s),
        .en          (en_s),
        .pix_en      (pix_s),
        .hSync       (hs_s),
        .vSync       (vs_s),
        .bright      (br_s),
        .hCount      (hc_s),
        .vCount      (vc_s),
        .pixel_x     (px_s),
        .pixel_y     (py_s),
        .line_start  (ls_s),
        .frame_start (fs_s)
    );

    int      checks = 0;
    int      errors = 0;
    int      cyc    = 0;
    mstate_t md, ms;
    obs_t    q_def[$];
    obs_t    q_sml[$];

    function automatic mstate_t m_step(mstate_t s, logic rst, logic en, int cdiv, int htot,
                                       int vtot);
        mstate_t n;
        n = s;
        if (rst) return '0;
        n.pix = 1'b0;
        n.ls  = 1'b0;
        n.fs  = 1'b0;
        if (en) begin
            if (s.div == cdiv - 1) begin
                n.div = 0;
                n.pix = 1'b1;
                if (s.h == htot - 1) begin
                    n.h  = 0;
                    n.ls = 1'b1;
                    if (s.v == vtot - 1) begin
                        n.v  = 0;
                        n.fs = 1'b1;
                    end else begin
                        n.v = s.v + 1;
                    end
                end else begin
                    n.h = s.h + 1;
                end
            end else begin
                n.div = s.div + 1;
            end
        end
        return n;
    endfunction

    function automatic obs_t m_obs(mstate_t s, int hsy, int hbp, int hact, int vsy, int vbp,
                                   int vact, logic hpol, logic vpol);
        obs_t o;
        logic b;
        b = (s.h >= hsy + hbp) && (s.h < hsy + hbp + hact) &&
            (s.v >= vsy + vbp) && (s.v < vsy + vbp + vact);
        o.pix = s.pix;
        o.ls  = s.ls;
        o.fs  = s.fs;
        o.hs  = (s.h < hsy) ? hpol : !hpol;
        o.vs  = (s.v < vsy) ? vpol : !vpol;
        o.br  = b;
        o.hc  = 10'(s.h);
        o.vc  = 10'(s.v);
        o.px  = b ? 10'(s.h - hsy - hbp) : 10'd0;
        o.py  = b ? 10'(s.v - vsy - vbp) : 10'd0;
        return o;
    endfunction

    function automatic obs_t exp_def(mstate_t s);
        return m_obs(s, 96, 48, 640, 2, 33, 480, 1'b0, 1'b0);
    endfunction

    function automatic obs_t exp_sml(mstate_t s);
        return m_obs(s, 2, 1, 4, 1, 1, 3, 1'b1, 1'b1);
    endfunction

    task automatic cmp_def();
        obs_t e, a;
        e = q_def.pop_front();
        a = '{pix_d, hs_d, vs_d, br_d, ls_d, fs_d, hc_d, vc_d, px_d, py_d};
        checks++;
        assert (a === e) else begin
            errors++;
            $error("FAIL def_obs cyc=%0d act=%h exp=%h", cyc, a, e);
        end
    endtask

    task automatic cmp_sml();
        obs_t e, a;
        e = q_sml.pop_front();
        a = '{pix_s, hs_s, vs_s, br_s, ls_s, fs_s, {6'd0, hc_s}, {6'd0, vc_s},
              {6'd0, px_s}, {6'd0, py_s}};
        checks++;
        assert (a === e) else begin
            errors++;
            $error("FAIL sml_obs cyc=%0d act=%h exp=%h", cyc, a, e);
        end
    endtask

    task automatic check_int(string tag, int act, int exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // Predict both instances across the next edge, then compare just after it.
    task automatic cycle();
        md = m_step(md, rst_d, en_d, 4, 800, 525);
        ms = m_step(ms, rst_s, en_s, 1, 8, 6);
        q_def.push_back(exp_def(md));
        q_sml.push_back(exp_sml(ms));
        @(posedge clk);
        #1;
        cyc++;
        cmp_def();
        cmp_sml();
    endtask

    initial begin
        int first_pix, last_fs, last_ls, guard, n, nfs, nls;
        rst_d = 1'b1;
        rst_s = 1'b1;
        en_d  = 1'b1;
        en_s  = 1'b1;
        md    = '0;
        ms    = '0;

        repeat (5) cycle();
        rst_d = 1'b0;
        rst_s = 1'b0;

        first_pix = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (first_pix == 0 && pix_d) first_pix = i;
        end
        check_int("first_pix_edge", first_pix, 4);

        last_fs = -1;
        last_ls = -1;
        for (int i = 0; i < 150; i++) begin
            cycle();
            if (ls_s) begin
                if (last_ls >= 0) check_int("sml_line_len", cyc - last_ls, 8);
                last_ls = cyc;
            end
            if (fs_s) begin
                if (last_fs >= 0) check_int("sml_frame_len", cyc - last_fs, 48);
                last_fs = cyc;
            end
        end

        guard = 0;
        while (md.h != 300 && guard < 2000) begin
            en_s = ($urandom_range(0, 3) != 0);
            cycle();
            guard++;
        end
        check_int("reach_h300", int'(hc_d), 300);
        en_s = 1'b1;

        repeat (2) cycle();
        en_d = 1'b0;
        repeat (20) cycle();
        check_int("freeze_hcount", int'(hc_d), 300);
        en_d = 1'b1;
        n = 0;
        while (hc_d != 10'd301 && n < 10) begin
            cycle();
            n++;
        end
        check_int("resume_edges", n, 2);

        guard = 0;
        while (!(ms.h == 5 && ms.v == 3) && guard < 100) begin
            cycle();
            guard++;
        end
        check_int("sml_reach_pos", int'(hc_s) * 16 + int'(vc_s), 5 * 16 + 3);
        rst_s = 1'b1;
        ms    = '0;
        q_sml.push_back(exp_sml(ms));
        #1;
        cmp_sml();
        repeat (3) cycle();
        rst_s = 1'b0;
        nfs = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (fs_s) nfs++;
        end
        check_int("no_spurious_fs", nfs, 0);

        last_ls = -1;
        nls     = 0;
        guard   = 0;
        while (nls < 2 && guard < 8000) begin
            cycle();
            guard++;
            if (ls_d) begin
                if (last_ls >= 0) check_int("def_line_len", cyc - last_ls, 3200);
                last_ls = cyc;
                nls++;
            end
        end
        check_int("def_line_seen", nls, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
